// File: rtl/rst_seq_pkg.sv
// rtl/rst_seq_pkg.sv - shared state encoding and stage indices for the reset sequencer
package rst_seq_pkg;

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_WAIT_LOCK = 3'd1,
    ST_REL0      = 3'd2,
    ST_REL1      = 3'd3,
    ST_REL2      = 3'd4,
    ST_RUN       = 3'd5,
    ST_RELOCK    = 3'd6
  } state_t;

  localparam int STG_TIMING = 0;
  localparam int STG_PIXEL  = 1;
  localparam int STG_OUT    = 2;

  localparam logic [2:0] STG_ALL = 3'b111;

endpackage

// File: rtl/rst_sync_bit.sv
// rtl/rst_sync_bit.sv - single-bit flop-chain synchronizer with configurable depth and reset value
module rst_sync_bit #(
  parameter int   DEPTH   = 2,
  parameter logic RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic [DEPTH-1:0] chain;

  always_ff @(posedge clk) begin
    if (rst) begin
      chain <= {DEPTH{RST_VAL}};
    end else begin
      chain <= {chain[DEPTH-2:0], d};
    end
  end

  assign q = chain[DEPTH-1];

endmodule

// File: rtl/rst_seq_rx.sv
// rtl/rst_seq_rx.sv - staged reset release sequencer gated on DCM lock
// Optional lock-loss counter: RST_SEQ_LOSS_CNT_EN
module rst_seq_rx
  import rst_seq_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int HOLD_CYC    = 16,
  parameter int LOCK_TMO    = 4096
) (
  input  logic       CLK_40M,
  input  logic       SYS_RST,
  input  logic       RST_REQ_ASYNC,
  input  logic       LOCKED_ASYNC,
  output logic [2:0] RST_STAGE,
  output logic       DCM_RST_REQ,
  output logic       READY,
  output logic [7:0] LOSS_CNT
);

  localparam logic [15:0] HOLD_LOAD = 16'(HOLD_CYC - 1);
  localparam logic [15:0] TMO_LOAD  = 16'(LOCK_TMO - 1);

  logic        req_s;
  logic        lock_s;
  state_t      state;
  logic [15:0] cnt;
  logic [2:0]  rst_stage;
  logic        dcm_rst_req;
  logic        ready;
  logic        loss_evt;

  // Request chain resets asserted so nothing releases before it has been sampled.
  rst_sync_bit #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b1)) u_req_sync (
    .clk (CLK_40M),
    .rst (SYS_RST),
    .d   (RST_REQ_ASYNC),
    .q   (req_s)
  );

  rst_sync_bit #(.DEPTH(SYNC_STAGES), .RST_VAL(1'b0)) u_lock_sync (
    .clk (CLK_40M),
    .rst (SYS_RST),
    .d   (LOCKED_ASYNC),
    .q   (lock_s)
  );

  // An external request outranks a lock loss, so a loss is only counted without one.
  assign loss_evt = (state inside {ST_REL0, ST_REL1, ST_REL2, ST_RUN}) && !req_s && !lock_s;

  always_ff @(posedge CLK_40M) begin
    if (SYS_RST) begin
      state       <= ST_HOLD;
      rst_stage   <= STG_ALL;
      dcm_rst_req <= 1'b0;
      ready       <= 1'b0;
      cnt         <= 16'd0;
    end else begin
      dcm_rst_req <= 1'b0;
      if (req_s && state != ST_HOLD) begin
        state     <= ST_HOLD;
        rst_stage <= STG_ALL;
        ready     <= 1'b0;
        cnt       <= 16'd0;
      end else if (loss_evt) begin
        state       <= ST_RELOCK;
        rst_stage   <= STG_ALL;
        ready       <= 1'b0;
        dcm_rst_req <= 1'b1;
        cnt         <= 16'd0;
      end else begin
        case (state)
          ST_HOLD: begin
            rst_stage <= STG_ALL;
            if (!req_s) begin
              state <= ST_WAIT_LOCK;
              cnt   <= TMO_LOAD;
            end
          end
          ST_WAIT_LOCK: begin
            if (lock_s) begin
              state                 <= ST_REL0;
              rst_stage[STG_TIMING] <= 1'b0;
              cnt                   <= HOLD_LOAD;
            end else if (cnt == 16'd0) begin
              state       <= ST_RELOCK;
              dcm_rst_req <= 1'b1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          ST_REL0: begin
            if (cnt == 16'd0) begin
              state                <= ST_REL1;
              rst_stage[STG_PIXEL] <= 1'b0;
              cnt                  <= HOLD_LOAD;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          ST_REL1: begin
            if (cnt == 16'd0) begin
              state              <= ST_REL2;
              rst_stage[STG_OUT] <= 1'b0;
              cnt                <= HOLD_LOAD;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          ST_REL2: begin
            if (cnt == 16'd0) begin
              state <= ST_RUN;
              ready <= 1'b1;
            end else begin
              cnt <= cnt - 16'd1;
            end
          end
          ST_RUN: begin
            ready <= 1'b1;
          end
          ST_RELOCK: begin
            state <= ST_HOLD;
            cnt   <= 16'd0;
          end
          default: begin
            state     <= ST_HOLD;
            rst_stage <= STG_ALL;
            ready     <= 1'b0;
            cnt       <= 16'd0;
          end
        endcase
      end
    end
  end

`ifdef RST_SEQ_LOSS_CNT_EN
  logic [7:0] loss_cnt;

  always_ff @(posedge CLK_40M) begin
    if (SYS_RST) begin
      loss_cnt <= 8'h00;
    end else if (loss_evt && loss_cnt != 8'hFF) begin
      loss_cnt <= loss_cnt + 8'h01;
    end
  end

  assign LOSS_CNT = loss_cnt;
`else
  assign LOSS_CNT = 8'h00;
`endif

  assign RST_STAGE   = rst_stage;
  assign DCM_RST_REQ = dcm_rst_req;
  assign READY       = ready;

endmodule

// File: tb/tb_rst_seq_rx.sv
// tb/tb_rst_seq_rx.sv - directed self-checking bench for rst_seq_rx
module tb_rst_seq_rx;

`ifdef RST_SEQ_LOSS_CNT_EN
  localparam bit CNT_EN = 1'b1;
`else
  localparam bit CNT_EN = 1'b0;
`endif

  logic       clk;
  logic       sys_rst;
  logic       req_async;
  logic       lock_async;
  logic [2:0] rst_stage;
  logic       dcm_rst_req;
  logic       ready;
  logic [7:0] loss_cnt;

  int n_chk  = 0;
  int n_fail = 0;

  rst_seq_rx dut (
    .CLK_40M       (clk),
    .SYS_RST       (sys_rst),
    .RST_REQ_ASYNC (req_async),
    .LOCKED_ASYNC  (lock_async),
    .RST_STAGE     (rst_stage),
    .DCM_RST_REQ   (dcm_rst_req),
    .READY         (ready),
    .LOSS_CNT      (loss_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] exp_loss(input int n);
    if (!CNT_EN) return 8'h00;
    return (n > 255) ? 8'hFF : 8'(n);
  endfunction

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_stage(input logic [2:0] exp, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      tick(1);
      if (rst_stage === exp) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  initial begin
    int pulses;
    int bad;
    int tmo;
    bit ok;

    sys_rst    = 1'b1;
    req_async  = 1'b0;
    lock_async = 1'b1;
    tick(3);
    chk("reset_stage", 32'(rst_stage), 32'h7);
    chk("reset_ready", 32'(ready), 32'h0);
    chk("reset_dcm", 32'(dcm_rst_req), 32'h0);
    chk("reset_loss", 32'(loss_cnt), 32'h0);

    // Power-up release: 111 -> 110 -> 100 -> 000 at 16-cycle spacing
    sys_rst = 1'b0;
    tick(3);
    chk("seq_hold", 32'(rst_stage), 32'h7);
    tick(1);
    chk("seq_rel0", 32'(rst_stage), 32'h6);
    tick(15);
    chk("seq_rel0_end", 32'(rst_stage), 32'h6);
    tick(1);
    chk("seq_rel1", 32'(rst_stage), 32'h4);
    tick(16);
    chk("seq_rel2", 32'(rst_stage), 32'h0);
    chk("seq_rel2_ready", 32'(ready), 32'h0);
    tick(15);
    chk("seq_pre_run_ready", 32'(ready), 32'h0);
    tick(1);
    chk("seq_run_ready", 32'(ready), 32'h1);
    chk("seq_run_stage", 32'(rst_stage), 32'h0);

    // Lock lost in RUN: all stages asserted on the third edge
    lock_async = 1'b0;
    tick(2);
    chk("loss_before", 32'(rst_stage), 32'h0);
    tick(1);
    chk("loss_stage", 32'(rst_stage), 32'h7);
    chk("loss_dcm", 32'(dcm_rst_req), 32'h1);
    chk("loss_ready", 32'(ready), 32'h0);
    chk("loss_cnt_1", 32'(loss_cnt), 32'(exp_loss(1)));
    tick(1);
    chk("loss_dcm_off", 32'(dcm_rst_req), 32'h0);

    // Lock timeout: 4096 cycles in WAIT_LOCK with no pulse, then one pulse
    pulses = 0;
    bad    = 0;
    for (int i = 0; i < 4096; i++) begin
      tick(1);
      if (dcm_rst_req) pulses++;
      if (rst_stage !== 3'b111) bad++;
    end
    chk("tmo_no_early_pulse", 32'(pulses), 32'h0);
    chk("tmo_stage_held", 32'(bad), 32'h0);
    tick(1);
    chk("tmo_pulse", 32'(dcm_rst_req), 32'h1);
    chk("tmo_stage", 32'(rst_stage), 32'h7);
    tick(1);
    chk("tmo_pulse_end", 32'(dcm_rst_req), 32'h0);
    chk("tmo_loss_unchanged", 32'(loss_cnt), 32'(exp_loss(1)));

    // Request and lock loss together in REL1: request wins, no loss recorded
    lock_async = 1'b1;
    tick(3);
    chk("both_rel0", 32'(rst_stage), 32'h6);
    tick(16);
    chk("both_rel1", 32'(rst_stage), 32'h4);
    req_async  = 1'b1;
    lock_async = 1'b0;
    tick(2);
    chk("both_before", 32'(rst_stage), 32'h4);
    tick(1);
    chk("both_stage", 32'(rst_stage), 32'h7);
    chk("both_dcm", 32'(dcm_rst_req), 32'h0);
    chk("both_loss", 32'(loss_cnt), 32'(exp_loss(1)));
    tick(1);
    chk("both_dcm_after", 32'(dcm_rst_req), 32'h0);
    chk("both_loss_after", 32'(loss_cnt), 32'(exp_loss(1)));

    // 300 forced losses to reach saturation
    req_async = 1'b0;
    tmo = 0;
    for (int i = 0; i < 300; i++) begin
      lock_async = 1'b1;
      wait_stage(3'b110, 40, ok);
      if (!ok) tmo++;
      lock_async = 1'b0;
      wait_stage(3'b111, 10, ok);
      if (!ok) tmo++;
      if (i == 100) chk("sat_mid", 32'(loss_cnt), 32'(exp_loss(102)));
      if (i == 253) chk("sat_reach", 32'(loss_cnt), 32'(exp_loss(255)));
    end
    chk("sat_timeouts", 32'(tmo), 32'h0);
    chk("sat_final", 32'(loss_cnt), 32'(CNT_EN ? 8'hFF : 8'h00));

    // SYS_RST pulse in REL2, then full restart
    lock_async = 1'b1;
    wait_stage(3'b100, 60, ok);
    chk("rst2_reach_rel1", 32'(ok), 32'h1);
    tick(16);
    chk("rst2_rel2", 32'(rst_stage), 32'h0);
    tick(2);
    sys_rst = 1'b1;
    tick(1);
    sys_rst = 1'b0;
    chk("rst2_stage", 32'(rst_stage), 32'h7);
    chk("rst2_ready", 32'(ready), 32'h0);
    chk("rst2_dcm", 32'(dcm_rst_req), 32'h0);
    chk("rst2_loss", 32'(loss_cnt), 32'h0);
    tick(3);
    chk("rst2_hold", 32'(rst_stage), 32'h7);
    tick(1);
    chk("rst2_rel0", 32'(rst_stage), 32'h6);
    tick(16);
    chk("rst2_rel1", 32'(rst_stage), 32'h4);
    tick(16);
    chk("rst2_rel2b", 32'(rst_stage), 32'h0);
    tick(16);
    chk("rst2_run", 32'(ready), 32'h1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/rst_seq_rx.md
RST_SEQ_RX -- requirements
Module: rst_seq_rx

Interface
REQ-001 SHALL have parameter SYNC_STAGES, default 2: number of flops in each async-input synchronizer (legal range 2..4).
REQ-002 SHALL have parameter HOLD_CYC, default 16: cycles each reset stage is held after the previous stage releases (legal range 1..255).
REQ-003 SHALL have parameter LOCK_TMO, default 4096: cycles allowed in WAIT_LOCK before a relock request (legal range 16..65535).
REQ-004 SHALL have port CLK_40M, input, 1 bit: the only clock; all logic is sampled on its rising edge.
REQ-005 SHALL have port SYS_RST, input, 1 bit: synchronous, active-high reset.
REQ-006 SHALL have port RST_REQ_ASYNC, input, 1 bit: asynchronous reset request from the 50 MHz domain, active-high.
REQ-007 SHALL have port LOCKED_ASYNC, input, 1 bit: asynchronous DCM lock status, high = locked.
REQ-008 SHALL have port RST_STAGE, output, 3 bits: per-stage active-high resets; [0] = timing, [1] = pixel pipe, [2] = output drive.
REQ-009 SHALL have port DCM_RST_REQ, output, 1 bit: single-cycle pulse requesting a DCM re-reset.
REQ-010 SHALL have port READY, output, 1 bit: high only in RUN.
REQ-011 SHALL have port LOSS_CNT, output, 8 bits: count of lock-loss events.

Function
REQ-012 SHALL pass RST_REQ_ASYNC and LOCKED_ASYNC each through a SYNC_STAGES flop chain; synchronized versions are req_s and lock_s.
REQ-013 SHALL implement states HOLD, WAIT_LOCK, REL0, REL1, REL2, RUN and RELOCK.
REQ-014 SHALL, in HOLD, assert RST_STAGE=3'b111 and go to WAIT_LOCK on the first cycle with req_s=0.
REQ-015 SHALL, in WAIT_LOCK, count cycles: lock_s=1 -> REL0 (counter cleared); counter reaching LOCK_TMO-1 with lock_s=0 -> RELOCK.
REQ-016 SHALL, in REL0, deassert RST_STAGE[0] on entry, hold for HOLD_CYC cycles, then go to REL1.
REQ-017 SHALL, in REL1, deassert RST_STAGE[1] on entry, hold for HOLD_CYC cycles, then go to REL2.
REQ-018 SHALL, in REL2, deassert RST_STAGE[2] on entry, hold for HOLD_CYC cycles, then go to RUN.
REQ-019 SHALL release stages in strict order 0 -> 1 -> 2, with no two stages released in the same cycle.
REQ-020 SHALL, in RELOCK, pulse DCM_RST_REQ high for exactly 1 cycle, then enter HOLD.
REQ-021 SHALL, in any state other than HOLD, respond to req_s=1 by going to HOLD on the next cycle and asserting all RST_STAGE bits from that cycle; req_s takes priority over lock loss.
REQ-022 SHALL treat lock_s=0 in REL0, REL1, REL2 or RUN as a loss: all RST_STAGE bits asserted next cycle, LOSS_CNT incremented, next state RELOCK.
REQ-023 SHALL saturate LOSS_CNT at 8'hFF, with no wrap-around.
REQ-024 SHALL count the remaining HOLD_CYC and LOCK_TMO with a 16-bit down-counter, reloaded on every state entry.
REQ-025 SHALL drive all outputs from registers (no combinational path from input to output).

Reset
REQ-026 SHALL, on SYS_RST=1, set state=HOLD, RST_STAGE=3'b111, DCM_RST_REQ=0, READY=0, LOSS_CNT=0, counter=0, and synchronizer flops: req chain=1, lock chain=0.
REQ-027 SHALL let SYS_RST asserted mid-sequence override everything within the same clock edge.

Configuration
REQ-028 SHALL, with RST_SEQ_LOSS_CNT_EN defined, implement the LOSS_CNT register per REQ-022/023.
REQ-029 SHALL, without RST_SEQ_LOSS_CNT_EN, tie LOSS_CNT to 8'h00 and build no counter; all other behaviour is unchanged.

Structure
REQ-030 SHALL place the state enum type and the stage-index constants (STG_TIMING=0, STG_PIXEL=1, STG_OUT=2) in a shared package rst_seq_pkg.
REQ-031 SHALL implement the synchronizer as sub-module rst_sync_bit (parameterized depth, reset value as a parameter), instantiated twice.

Verification
REQ-032 SHALL cover: SYS_RST released, req low, lock high -> RST_STAGE goes 111 -> 110 -> 100 -> 000 at 16-cycle spacing, with READY=1 after the last stage.
REQ-033 SHALL cover: lock held low for 4096 cycles in WAIT_LOCK -> exactly one DCM_RST_REQ pulse, then HOLD, with RST_STAGE=111 throughout.
REQ-034 SHALL cover: lock dropped in RUN -> RST_STAGE=111 within SYNC_STAGES+1 cycles, LOSS_CNT 0 -> 1, and one DCM_RST_REQ pulse.
REQ-035 SHALL cover: RST_REQ_ASYNC and lock loss in the same cycle during REL1 -> HOLD, LOSS_CNT unchanged, and no DCM_RST_REQ.
REQ-036 SHALL cover: 300 forced lock losses -> LOSS_CNT=8'hFF (8'h00 when RST_SEQ_LOSS_CNT_EN is undefined).
REQ-037 SHALL cover: SYS_RST asserted for 1 cycle during REL2 -> all outputs at reset values on the next edge, followed by the full sequence restarting.
